// File: rtl/sipo_pkg.sv
// Shared types and default parameters for the sipo_rx receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } sipo_state_t;

  localparam int SIPO_DATA_W_DEF     = 8;
  localparam int SIPO_FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/sipo_fifo.sv
// Small synchronous FIFO holding received words; the head entry drives rdata directly.
module sipo_fifo
  import sipo_pkg::*;
#(
  parameter int DATA_W = SIPO_DATA_W_DEF,
  parameter int DEPTH  = SIPO_FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              wr_en;
  logic              rd_en;

  // A push while full only lands if the head is leaving on the same edge.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // NOTE: the storage is reset here so the head reads zero out of reset; it is
  // only DEPTH words, so the reset cost is trivial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + (PTR_W + 1)'(1);
      else if (rd_en && !wr_en) count <= count - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: start bit, DATA_W bits MSB first, words queued in a FIFO.
// Define SIPO_RX_FRAME_CHECK_EN to add a checked stop bit and the frame_err_o flag.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int DATA_W     = SIPO_DATA_W_DEF,
  parameter int FIFO_DEPTH = SIPO_FIFO_DEPTH_DEF
) (
  input  logic              sr_clk_i,
  input  logic              rst_i,
  input  logic              data_i,
  input  logic              err_clr_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(DATA_W);

  sipo_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;
  logic              word_done;
  logic [DATA_W-1:0] word;
  logic              full;
  logic              empty;
  logic              pop;
  logic              overrun_set;

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    word_done = 1'b0;
    word      = {shreg[DATA_W-2:0], data_i};
`ifdef SIPO_RX_FRAME_CHECK_EN
    if (state == STOP && data_i) begin
      word_done = 1'b1;
      word      = shreg;
    end
`else
    if (state == SHIFT && last_bit) word_done = 1'b1;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sr_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!data_i) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          shreg <= {shreg[DATA_W-2:0], data_i};
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
`ifdef SIPO_RX_FRAME_CHECK_EN
            state <= STOP;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop         = valid_o & ready_i;
  assign overrun_set = word_done & full & ~pop;
  assign valid_o     = ~empty;
  assign busy_o      = (state != IDLE);

  // A set on the same edge as a clear wins, so no event is ever lost.
  always_ff @(posedge sr_clk_i or negedge rst_i) begin
    if (!rst_i) overrun_o <= 1'b0;
    else        overrun_o <= overrun_set | (overrun_o & ~err_clr_i);
  end

`ifdef SIPO_RX_FRAME_CHECK_EN
  always_ff @(posedge sr_clk_i or negedge rst_i) begin
    if (!rst_i) frame_err_o <= 1'b0;
    else        frame_err_o <= ((state == STOP) & ~data_i) | (frame_err_o & ~err_clr_i);
  end
`else
  assign frame_err_o = 1'b0;
`endif

  sipo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sr_clk_i),
    .rst_n (rst_i),
    .push  (word_done),
    .pop   (pop),
    .wdata (word),
    .rdata (data_o),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: stimulus queues expected words, a monitor checks each pop.
module tb_sipo_rx;
  import sipo_pkg::*;

`ifdef SIPO_RX_FRAME_CHECK_EN
  localparam int BUSY_CYCLES = 9;
`else
  localparam int BUSY_CYCLES = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_i;
  logic       err_clr;
  logic       ready;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       overrun_o;
  logic       frame_err_o;

  int         checks = 0;
  int         errors = 0;
  int         busy_total = 0;
  int         valid_total = 0;
  logic [7:0] exp_q [$];

  sipo_rx dut (
    .sr_clk_i    (clk),
    .rst_i       (rst_n),
    .data_i      (data_i),
    .err_clr_i   (err_clr),
    .ready_i     (ready),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_bit);
    data_i = 1'b0;
    tick();
    for (int i = 7; i >= 0; i--) begin
      data_i = w[i];
      tick();
    end
`ifdef SIPO_RX_FRAME_CHECK_EN
    data_i = stop_bit;
    tick();
`endif
    data_i = 1'b1;
    tick();
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_o) busy_total++;
      if (valid_o) valid_total++;
      if (valid_o && ready) begin
        if (exp_q.size() == 0) check("unexpected_word", {24'd0, data_o}, 32'hFFFF_FFFF);
        else check("data_o", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int b0;
    int v0;
    rst_n   = 1'b0;
    data_i  = 1'b1;
    err_clr = 1'b0;
    ready   = 1'b0;
    tick();
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", data_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    tick();
    rst_n = 1'b1;

    // Idle line: nothing happens.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", valid_o, 0);
      check("idle_busy", busy_o, 0);
    end

    // Single frame with ready high.
    ready = 1'b1;
    b0 = busy_total;
    v0 = valid_total;
    exp_q.push_back(8'h2C);
    send_frame(8'h2C, 1'b1);
    tick();
    tick();
    check("f0_busy_cycles", busy_total - b0, BUSY_CYCLES);
    check("f0_valid_cycles", valid_total - v0, 1);
    check("f0_valid_after", valid_o, 0);

    // Two back-to-back frames buffered, then drained.
    ready = 1'b0;
    exp_q.push_back(8'hD2);
    exp_q.push_back(8'h2A);
    send_frame(8'hD2, 1'b1);
    send_frame(8'h2A, 1'b1);
    check("b2b_valid", valid_o, 1);
    check("b2b_head", data_o, 8'hD2);
    ready = 1'b1;
    repeat (4) tick();
    check("b2b_drained", valid_o, 0);
    check("b2b_queue", exp_q.size(), 0);

    // Overrun: five words into a four-deep FIFO.
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    check("ovr_set", overrun_o, 1);
    check("ovr_head", data_o, 8'h01);
    ready = 1'b1;
    repeat (6) tick();
    check("ovr_drained", valid_o, 0);
    check("ovr_queue", exp_q.size(), 0);
    check("ovr_sticky", overrun_o, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_cleared", overrun_o, 0);

`ifdef SIPO_RX_FRAME_CHECK_EN
    // Bad stop bit discards the word; a good one follows.
    v0 = valid_total;
    send_frame(8'h55, 1'b0);
    tick();
    check("ferr_set", frame_err_o, 1);
    check("ferr_no_word", valid_total - v0, 0);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1);
    tick();
    check("ferr_queue", exp_q.size(), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ferr_cleared", frame_err_o, 0);
`endif

    // Reset mid-frame with one word queued.
    ready = 1'b0;
    send_frame(8'h77, 1'b1);
    check("mid_queued", valid_o, 1);
    data_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_i = i[0];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    data_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (3) tick();
    check("post_rst_queue", exp_q.size(), 0);
    check("post_rst_valid", valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
